keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and produces debounced key events.
- Drives active-low column strobes one at a time and samples active-low row returns (pulled up off-chip).
- Shifts each accepted key code into a 32-bit nibble register that feeds the board's 8-digit hex display data input directly.
- Sits at board level alongside the display driver; the user-input path for lab designs.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is held active (dwell); legal range is 4 or more.
- DEBOUNCE_CNT, 100000, consecutive stable cycles required for press and for release acceptance; legal range is 2 or more.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; asynchronous, active-high
- row_i  input  4  keypad row lines, active-low, asynchronous to clk_i
- clr_i  input  1  synchronous clear of data_o
- col_o  output  4  column strobes, active-low, exactly one bit low at all times
- key_code_o  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}
- key_valid_o  output  1  one-cycle pulse when a press is accepted
- key_pressed_o  output  1  high while an accepted key is held
- data_o  output  32  shift register of accepted codes; newest code in [3:0]

Behaviour:
- Reset (async, active-high):
  - Outputs: col_o=4'b1110, key_code_o=0, key_valid_o=0, key_pressed_o=0, data_o=0.
  - Internal: state=SCAN, col_idx=0, dwell and debounce counters=0, synchronizer flops=4'hF.
- Synchronizer: row_i passes through 2 flops to give row_s. All decisions use row_s. Input-to-row_s latency is 2 cycles.
- SCAN state:
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the final dwell cycle, row_s is sampled.
  - If exactly one bit of row_s is low: capture row_idx (index of the low bit) and the current col_idx. Go to DEBOUNCE and clear the debounce counter. col_o is frozen.
  - Otherwise (all high, or 2 or more low, i.e. ghost rejection): col_idx increments modulo 4 and col_o rotates; 4'b0111 wraps to 4'b1110.
- DEBOUNCE state:
  - Each cycle row_s equals the captured one-cold pattern, the counter increments.
  - Any mismatch: return to SCAN, reset the dwell counter, advance col_idx. No event is emitted.
  - When the counter reaches DEBOUNCE_CNT-1 with a match:
    - Next cycle: key_valid_o=1 for exactly one cycle, key_code_o={row_idx,col_idx}, data_o={data_o[27:0], code}, key_pressed_o=1.
    - Go to HELD.
  - Latency is DEBOUNCE_CNT cycles from the sample cycle to the key_valid_o cycle.
- HELD state:
  - key_pressed_o=1; col_o stays frozen.
  - When row_s==4'hF: go to RELEASE and clear the counter.
  - Additional keys pressed while held are ignored (no rollover).
- RELEASE state:
  - Requires DEBOUNCE_CNT consecutive cycles of row_s==4'hF.
  - Any low bit first: back to HELD.
  - On completion: key_pressed_o=0 and go to SCAN. col_idx advances by 1 and the dwell counter resets.
- Code retention: key_code_o holds its value until the next accepted press.
- clr_i:
  - Sets data_o to 0 the next cycle in any state.
  - If clr_i and an acceptance coincide, data_o = {28'h0, code}; the clear is applied first, then the shift.
  - clr_i does not affect the FSM, key_code_o, or key_pressed_o.
- data_o after more than 8 presses: the oldest nibble is discarded off [31:28].
- Reset asserted mid-debounce or mid-hold: immediate return to the reset state; no pulse is emitted on deassertion.
- Counter widths: $clog2 of each parameter, with no overflow possible. Counter comparisons use the full parameter value.

Decomposition:
- keypad_pkg contains:
  - typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t
  - localparams NUM_ROWS=4, NUM_COLS=4
  - function onehot0_idx (returns the index and a single-low flag for a 4-bit active-low vector)
- One sub-module: sync_2ff, a parameterised-width 2-flop synchronizer with a reset value input. It is reused for other async board inputs.
- FSM, counters and the shift register stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
1. Reset and idle, rows=4'hF: col_o cycles 1110→1101→1011→0111→1110, changing every 4 clocks. key_valid_o is never asserted. data_o=0.
2. Clean press: row_i=4'b1011 held while col 1 is active (col_o=1101), then released.
   - Exactly one key_valid_o pulse, 8 cycles after the sample, with key_code_o=4'h9 and data_o=32'h9.
   - key_pressed_o falls 8 cycles after row_s returns to F.
3. Bounce: press row 0 on col 2 with glitches to 4'hF every 3 cycles for 20 cycles, then stable. Only one pulse occurs, after the stable run, with code 4'h2. No pulse during the glitching.
4. Ghost and rollover:
   - Rows 4'b1100 at sample: no event and scanning continues.
   - During HELD, press a second key: no second pulse.
   - After the full release: the next scan starts from the next column.
5. Sequence: accept codes 1,2,3,4,5,6,7,8,A in order → data_o=32'h2345678A. Then pulse clr_i alone → data_o=0. Then clr_i coincident with an acceptance of code 5 → data_o=32'h5.
6. Reset mid-operation: assert rst_i during DEBOUNCE (counter at 5) and during HELD. Outputs return to reset values within the same cycle. No key_valid_o pulse after deassertion while rows stay 4'hF.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// onehot0_idx decodes an active-low row vector into "exactly one line low" plus that line's index.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef struct packed {
        logic       single;
        logic [1:0] idx;
    } onehot0_t;

    function automatic onehot0_t onehot0_idx(input logic [NUM_ROWS-1:0] v);
        onehot0_t res;
        int       cnt;
        res.single = 1'b0;
        res.idx    = 2'd0;
        cnt        = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!v[i]) begin
                cnt++;
                res.idx = i[1:0];
            end
        end
        res.single = (cnt == 1);
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// The reset value is a port so idle-high inputs (pulled-up lines) do not glitch out of reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= i_rst_val;
            r_sync <= i_rst_val;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates one low column strobe, debounces a single-key press and release,
// and shifts each accepted {row,col} code into a 32-bit nibble register for the hex display.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  row_i,
    input  logic        clr_i,
    output logic [3:0]  col_o,
    output logic [3:0]  key_code_o,
    output logic        key_valid_o,
    output logic        key_pressed_o,
    output logic [31:0] data_o
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    // The sample (or first idle) cycle already counts as stable, so the counter stops one short.
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 2);

    logic [NUM_ROWS-1:0] w_row_s;
    onehot0_t            w_scan;
    kp_state_t           r_state;
    kp_state_t           w_state_next;
    logic [1:0]          r_col_idx;
    logic [1:0]          r_row_idx;
    logic [DW-1:0]       r_dwell;
    logic [CW-1:0]       r_deb;
    logic [NUM_ROWS-1:0] r_row_cap;
    logic [3:0]          r_key_code;
    logic                r_key_valid;
    logic                r_key_pressed;
    logic [31:0]         r_data;
    logic                w_dwell_last;
    logic                w_deb_last;
    logic                w_match;
    logic                w_rows_idle;
    logic                w_capture;
    logic                w_accept;
    logic                w_col_adv;
    logic                w_release_done;
    logic                w_dwell_inc;
    logic                w_deb_inc;
    logic [3:0]          w_code;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_rst_val ({NUM_ROWS{1'b1}}),
        .i_d       (row_i),
        .o_q       (w_row_s)
    );

    assign w_scan       = onehot0_idx(w_row_s);
    assign w_dwell_last = (r_dwell == DWELL_LAST);
    assign w_deb_last   = (r_deb == DEB_LAST);
    assign w_match      = (w_row_s == r_row_cap);
    assign w_rows_idle  = (w_row_s == {NUM_ROWS{1'b1}});
    assign w_code       = {r_row_idx, r_col_idx};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCAN:     if (w_dwell_last && w_scan.single) w_state_next = DEBOUNCE;
            DEBOUNCE: if (!w_match) w_state_next = SCAN;
                      else if (w_deb_last) w_state_next = HELD;
            HELD:     if (w_rows_idle) w_state_next = RELEASE;
            RELEASE:  if (!w_rows_idle) w_state_next = HELD;
                      else if (w_deb_last) w_state_next = SCAN;
        endcase
    end

    always_comb begin
        w_capture      = 1'b0;
        w_accept       = 1'b0;
        w_col_adv      = 1'b0;
        w_release_done = 1'b0;
        w_dwell_inc    = 1'b0;
        w_deb_inc      = 1'b0;
        case (r_state)
            SCAN: begin
                w_dwell_inc = !w_dwell_last;
                w_capture   = w_dwell_last && w_scan.single;
                w_col_adv   = w_dwell_last && !w_scan.single;
            end
            DEBOUNCE: begin
                w_col_adv = !w_match;
                w_accept  = w_match && w_deb_last;
                w_deb_inc = w_match && !w_deb_last;
            end
            HELD: ;
            RELEASE: begin
                w_release_done = w_rows_idle && w_deb_last;
                w_col_adv      = w_release_done;
                w_deb_inc      = w_rows_idle && !w_deb_last;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_col_idx     <= 2'd0;
            r_row_idx     <= 2'd0;
            r_dwell       <= '0;
            r_deb         <= '0;
            r_row_cap     <= {NUM_ROWS{1'b1}};
            r_key_code    <= 4'h0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
            r_data        <= 32'h0;
        end else begin
            // Both counters idle at zero outside their own phase, so entering a phase starts from zero.
            r_dwell     <= w_dwell_inc ? r_dwell + 1'b1 : '0;
            r_deb       <= w_deb_inc ? r_deb + 1'b1 : '0;
            r_key_valid <= w_accept;
            if (w_col_adv) r_col_idx <= r_col_idx + 2'd1;
            if (w_capture) begin
                r_row_idx <= w_scan.idx;
                r_row_cap <= w_row_s;
            end
            if (w_accept) begin
                r_key_code    <= w_code;
                r_key_pressed <= 1'b1;
            end else if (w_release_done) begin
                r_key_pressed <= 1'b0;
            end
            if (clr_i) r_data <= w_accept ? {28'h0, w_code} : 32'h0;
            else if (w_accept) r_data <= {r_data[27:0], w_code};
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
            assign col_o[gi] = (r_col_idx != 2'(gi));
        end
    endgenerate

    assign key_code_o    = r_key_code;
    assign key_valid_o   = r_key_valid;
    assign key_pressed_o = r_key_pressed;
    assign data_o        = r_data;

endmodule
